// File: rtl/rx_elastic_fifo_pkg.sv
// rx_efifo_pkg: shared constants for the receive elastic FIFO
package rx_efifo_pkg;
  localparam int DEF_DATA_W = 24;
  localparam int SYNC_BIT = DEF_DATA_W;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AFULL_TH = 8;
  localparam int DEF_AEMPTY_TH = 3;
  localparam logic [7:0] LOCK_BYTE_RESET = 8'hFF;
endpackage

// File: rtl/rx_elastic_fifo_if.sv
// rx_elastic_fifo_if: gearbox write side, decoder read side and status of the receive elastic FIFO
interface rx_elastic_fifo_if import rx_efifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW = $clog2(DEF_DEPTH)
);
  logic wr_en;
  logic [DATA_W:0] wr_data;
  logic rd_pop;
  logic [DATA_W-1:0] rd_data;
  logic rd_valid;
  logic rd_issync;
  logic [AW:0] level;
  logic almost_empty;
  logic drop_pulse;
  logic overflow;
  logic underflow;
  logic clr_sticky;
  logic [7:0] sync_word;
  logic sync_word_en;
  modport master (
    output wr_en, wr_data, rd_pop, clr_sticky,
    input rd_data, rd_valid, rd_issync, level, almost_empty, drop_pulse, overflow, underflow, sync_word, sync_word_en
  );
  modport slave (
    input wr_en, wr_data, rd_pop, clr_sticky,
    output rd_data, rd_valid, rd_issync, level, almost_empty, drop_pulse, overflow, underflow, sync_word, sync_word_en
  );
endinterface

// File: rtl/rx_elastic_fifo_mem.sv
// rx_efifo_mem: unreset register array with one write port and an asynchronous read port
module rx_efifo_mem #(
  parameter int W = 25,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [W-1:0] wdata,
  input logic [AW-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [DEPTH];
  // storage write
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/rx_elastic_fifo.sv
// rx_elastic_fifo: show-ahead receive elastic buffer with force-drop occupancy bound and lock-byte capture
module rx_elastic_fifo import rx_efifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AFULL_TH = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input logic clk,
  input logic reset,
  rx_elastic_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic [DATA_W:0] head;
  logic valid, issync, full, force_adv, pop_ok, adv, do_wr;
  logic drop_q, ovf_q, unf_q, sw_en_q;
  logic [7:0] sw_q;
  assign level = wr_ptr - rd_ptr;
  assign valid = level != '0;
  assign issync = head[DATA_W] & valid;
  assign full = level == (AW+1)'(DEPTH);
  assign force_adv = level >= (AW+1)'(AFULL_TH);
  assign pop_ok = bus.rd_pop & valid;
  assign adv = pop_ok | force_adv;
  assign do_wr = bus.wr_en & (!full | adv);
  rx_efifo_mem #(.W(DATA_W+1), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(do_wr),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(bus.wr_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(head)
  );
  assign bus.level = level;
  assign bus.rd_valid = valid;
  assign bus.rd_data = head[DATA_W-1:0];
  assign bus.rd_issync = issync;
  assign bus.almost_empty = level <= (AW+1)'(AEMPTY_TH);
  assign bus.drop_pulse = drop_q;
  assign bus.overflow = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.sync_word = sw_q;
  assign bus.sync_word_en = sw_en_q;
  // pointer advance, registered status flags and remote lock-byte capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      sw_q <= LOCK_BYTE_RESET;
      sw_en_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (adv) rd_ptr <= rd_ptr + 1'b1;
      drop_q <= force_adv & !pop_ok;
      ovf_q <= (bus.wr_en & full & !adv) | (ovf_q & !bus.clr_sticky);
      unf_q <= (bus.rd_pop & !valid) | (unf_q & !bus.clr_sticky);
      sw_en_q <= issync & adv;
      if (issync & adv) sw_q <= head[7:0];
    end
endmodule

// File: tb/tb_rx_elastic_fifo.sv
// tb_rx_elastic_fifo: randomized scoreboard bench over three FIFO configurations sharing one stimulus stream
module tb_rx_elastic_fifo;
  typedef struct packed {
    logic [5:0] level;
    logic valid;
    logic [23:0] data;
    logic issync;
    logic ae;
    logic dp;
    logic ovf;
    logic unf;
    logic [7:0] sw;
    logic swen;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx_elastic_fifo_if #(.DATA_W(24), .AW(4)) if0 ();
  rx_elastic_fifo_if #(.DATA_W(24), .AW(4)) if1 ();
  rx_elastic_fifo_if #(.DATA_W(24), .AW(2)) if2 ();

  rx_elastic_fifo #(.DATA_W(24), .DEPTH(16), .AFULL_TH(8), .AEMPTY_TH(3)) u0 (.clk(clk), .reset(reset), .bus(if0));
  rx_elastic_fifo #(.DATA_W(24), .DEPTH(16), .AFULL_TH(16), .AEMPTY_TH(3)) u1 (.clk(clk), .reset(reset), .bus(if1));
  rx_elastic_fifo #(.DATA_W(24), .DEPTH(4), .AFULL_TH(4), .AEMPTY_TH(3)) u2 (.clk(clk), .reset(reset), .bus(if2));

  int n_cmp = 0;
  int n_err = 0;
  obs_t exp_q [$];

  int dep [3] = '{16, 16, 4};
  int af [3] = '{8, 16, 4};
  int cnt [3];
  logic [24:0] mm [3][16];
  logic ovf_m [3];
  logic unf_m [3];
  logic dp_m [3];
  logic swen_m [3];
  logic [7:0] sw_m [3];

  task automatic chk(input int k, input string name, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL u%0d %s: got %0h expected %0h at %0t", k, name, a, e, $time);
    end
  endtask

  function automatic obs_t mk(input logic [5:0] lv, input logic v, input logic [23:0] d, input logic s,
                              input logic ae, input logic dp, input logic ov, input logic un,
                              input logic [7:0] sw, input logic swen);
    obs_t o;
    o.level = lv; o.valid = v; o.data = d; o.issync = s; o.ae = ae;
    o.dp = dp; o.ovf = ov; o.unf = un; o.sw = sw; o.swen = swen;
    return o;
  endfunction

  function automatic obs_t snap(input int k);
    return k == 0 ? mk(6'(if0.level), if0.rd_valid, if0.rd_data, if0.rd_issync, if0.almost_empty, if0.drop_pulse,
                       if0.overflow, if0.underflow, if0.sync_word, if0.sync_word_en) :
           k == 1 ? mk(6'(if1.level), if1.rd_valid, if1.rd_data, if1.rd_issync, if1.almost_empty, if1.drop_pulse,
                       if1.overflow, if1.underflow, if1.sync_word, if1.sync_word_en) :
                    mk(6'(if2.level), if2.rd_valid, if2.rd_data, if2.rd_issync, if2.almost_empty, if2.drop_pulse,
                       if2.overflow, if2.underflow, if2.sync_word, if2.sync_word_en);
  endfunction

  task automatic cmp(input int k, input obs_t a, input obs_t e);
    chk(k, "level", 32'(a.level), 32'(e.level));
    chk(k, "rd_valid", 32'(a.valid), 32'(e.valid));
    if (e.valid) chk(k, "rd_data", 32'(a.data), 32'(e.data));
    chk(k, "rd_issync", 32'(a.issync), 32'(e.issync));
    chk(k, "almost_empty", 32'(a.ae), 32'(e.ae));
    chk(k, "drop_pulse", 32'(a.dp), 32'(e.dp));
    chk(k, "overflow", 32'(a.ovf), 32'(e.ovf));
    chk(k, "underflow", 32'(a.unf), 32'(e.unf));
    chk(k, "sync_word", 32'(a.sw), 32'(e.sw));
    chk(k, "sync_word_en", 32'(a.swen), 32'(e.swen));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; ovf_m[k] = 0; unf_m[k] = 0; dp_m[k] = 0; swen_m[k] = 0; sw_m[k] = 8'hFF;
    end
  endtask

  task automatic model_cycle(input int k, input logic we, input logic [24:0] wd, input logic pop, input logic clr);
    int n = cnt[k];
    logic forced = n >= af[k];
    logic popok = pop && n > 0;
    logic leave = forced || popok;
    logic acc = we && (n < dep[k] || leave);
    swen_m[k] = leave && n > 0 && mm[k][0][24];
    if (swen_m[k]) sw_m[k] = mm[k][0][7:0];
    dp_m[k] = forced && !popok;
    ovf_m[k] = (we && !acc) || (ovf_m[k] && !clr);
    unf_m[k] = (pop && n == 0) || (unf_m[k] && !clr);
    if (leave && n > 0) begin
      for (int i = 0; i < n - 1; i++) mm[k][i] = mm[k][i+1];
      n--;
    end
    if (acc) begin
      mm[k][n] = wd;
      n++;
    end
    cnt[k] = n;
  endtask

  function automatic obs_t expect_obs(input int k);
    logic v = cnt[k] > 0;
    return mk(6'(cnt[k]), v, v ? mm[k][0][23:0] : 24'h0, v && mm[k][0][24], cnt[k] <= 3,
              dp_m[k], ovf_m[k], unf_m[k], sw_m[k], swen_m[k]);
  endfunction

  task automatic step(input logic we, input logic [24:0] wd, input logic pop, input logic clr);
    @(negedge clk);
    if0.wr_en = we; if0.wr_data = wd; if0.rd_pop = pop; if0.clr_sticky = clr;
    if1.wr_en = we; if1.wr_data = wd; if1.rd_pop = pop; if1.clr_sticky = clr;
    if2.wr_en = we; if2.wr_data = wd; if2.rd_pop = pop; if2.clr_sticky = clr;
    for (int k = 0; k < 3; k++) begin
      model_cycle(k, we, wd, pop, clr);
      exp_q.push_back(expect_obs(k));
    end
  endtask

  task automatic check_reset();
    for (int k = 0; k < 3; k++)
      cmp(k, snap(k), mk(6'd0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0));
  endtask

  task automatic async_reset();
    @(negedge clk);
    step_idle_inputs();
    #1 reset = 1'b1;
    #1 check_reset();
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic step_idle_inputs();
    if0.wr_en = 0; if0.rd_pop = 0; if0.clr_sticky = 0;
    if1.wr_en = 0; if1.rd_pop = 0; if1.clr_sticky = 0;
    if2.wr_en = 0; if2.rd_pop = 0; if2.clr_sticky = 0;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    while (exp_q.size() >= 3)
      for (int k = 0; k < 3; k++) cmp(k, snap(k), exp_q.pop_front());
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    step_idle_inputs();
    if0.wr_data = '0; if1.wr_data = '0; if2.wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset();
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) step(1'b1, 25'(i), 1'b0, 1'b0);
    for (int i = 4; i <= 13; i++) step(1'b1, 25'(i), 1'b0, 1'b0);
    for (int i = 14; i <= 20; i++) step(1'b1, 25'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    async_reset();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, {1'b1, 24'h0000A5}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, {1'b0, 24'h000042}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 25'(24'h100 + i), 1'b0, 1'b0);
    async_reset();
    step(1'b1, {1'b0, 24'h00BEEF}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, {$urandom_range(0, 3) == 0, 24'($urandom)},
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    step(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk(0, "scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
